// File: rtl/multicycle_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl                                                            |
// | Multi-cycle RV32 control FSM: sequences fetch/decode/execute/memory/       |
// | writeback, drives datapath selects and counts retired instructions.        |
// | Optional: define MULTICYCLE_CTRL_TRAP_EN to trap on unrecognised opcodes.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_en,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
`ifdef MULTICYCLE_CTRL_TRAP_EN
  output logic             illegal,
`endif
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
`ifdef MULTICYCLE_CTRL_TRAP_EN
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd10
`else
    S_BRANCH = 4'd9
`endif
  } state_t;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_instret;

  // Only the opcode and instr[5] (load vs store) steer the sequence.
  wire w_unused_instr = ^instr[31:7];

  // State register and retire counter; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (instr[6:0])
            c_OP_LOAD,
            c_OP_STORE:  r_state <= S_MEMADR;
            c_OP_RTYPE:  r_state <= S_EXEC_R;
            c_OP_ITYPE:  r_state <= S_EXEC_I;
            c_OP_BRANCH: r_state <= S_BRANCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            default:     r_state <= S_TRAP;
`else
            default:     r_state <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR: r_state <= instr[5] ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
        S_EXEC_R: r_state <= S_ALUWB;
        S_EXEC_I: r_state <= S_ALUWB;
        S_ALUWB:  r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        S_TRAP:   r_state <= S_TRAP;
`endif
        default:  r_state <= S_FETCH;
      endcase
      if (retire) r_instret <= r_instret + c_CNT_ONE;
    end
  end

  // Moore decode of the state register; pc_en/ir_write/retire also see mem_ready or zero.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_en      = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        retire  = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_en     = zero;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MULTICYCLE_CTRL_TRAP_EN
  assign illegal = (r_state == S_TRAP);
`endif

  assign state   = r_state;
  assign instret = r_instret;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32 core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives the datapath selects: PC, IR, ALU operand muxes, register file write enable and memory request. The immediate generator's output reaches the ALU through the `alu_src_b` selects issued here. It also counts retired instructions.

## Interface
- `CNT_W`, 32, width of the retired-instruction counter.

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: IR contents; only `instr[6:0]` is decoded.
- `zero` in 1: ALU zero flag, sampled in BRANCH.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write strobe, qualifies `mem_req`.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: latch fetched word into IR.
- `pc_en` out 1: load PC from the result bus.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: ALU A select; 00 = PC, 01 = oldPC, 10 = rs1.
- `alu_src_b` out 2: ALU B select; 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = subtract, 10 = decode from funct fields.
- `result_src` out 2: result bus select; 00 = ALUOut, 01 = mem data, 10 = ALU result.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `instret` out CNT_W: retired-instruction count.
- `state` out 4: current state encoding, for debug.

## Operation
- The FSM is Moore except `pc_en`, `ir_write` and `retire`, which also depend on `mem_ready` or `zero` as noted. Any output not listed for a state is 0.
- **FETCH (0):**
  - Drives `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10.
  - When `mem_ready`=1: `ir_write`=1 and `pc_en`=1 (PC <- PC+4), then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE (1):**
  - Drives `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00; the branch target is latched into ALUOut.
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; anything else -> FETCH (see Configuration).
- **MEMADR (2):** drives `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Goes to MEMRD if `instr[5]`=0, otherwise MEMWR.
- **MEMRD (3):** drives `mem_req`=1, `adr_src`=1. Holds until `mem_ready`, then goes to MEMWB.
- **MEMWB (4):** drives `result_src`=01, `reg_write`=1, `retire`=1. Goes to FETCH.
- **MEMWR (5):** drives `mem_req`=1, `mem_we`=1, `adr_src`=1. Holds until `mem_ready`, then asserts `retire`=1 and goes to FETCH.
- **EXEC_R (6):** drives `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Goes to ALUWB.
- **EXEC_I (7):** drives `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Goes to ALUWB.
- **ALUWB (8):** drives `result_src`=00, `reg_write`=1, `retire`=1. Goes to FETCH.
- **BRANCH (9):** drives `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00. Sets `pc_en`=`zero`, asserts `retire`=1, goes to FETCH.
- **Memory handshake:**
  - `mem_req`, `mem_we` and `adr_src` stay stable from entry into a memory state until the cycle `mem_ready` is sampled high.
  - A `mem_ready` pulse in a non-memory state is ignored.
- **Retire counter:** `instret` increments on every `retire` cycle and wraps from 2^CNT_W-1 to 0.
- Unused encodings 10–15 return to FETCH on the next edge (11–15 only, when TRAP is compiled in).

## Timing
- **Reset values:**
  - `state`=FETCH and `instret`=0.
  - Because FETCH is active during reset: `mem_req`=1, `adr_src`=0, `alu_src_b`=10, `result_src`=10.
  - All other outputs are 0; `pc_en` and `ir_write` are 0 unless `mem_ready` is high.
- **Mid-operation reset:** `rst` abandons any state immediately and holds FETCH. `instret` clears and no partial `retire` is issued.
- **Latency with `mem_ready` tied high** (cycles from FETCH entry to next FETCH):

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type / I-type ALU | 4 |
  | beq | 3 |

  Each wait cycle adds 1.
- `retire` occurs in the final cycle of each instruction; there is never more than one `retire` per 3 cycles.

## Configuration
- **`MULTICYCLE_CTRL_TRAP_EN` defined:**
  - Adds state TRAP (10). An unrecognised opcode in DECODE goes to TRAP.
  - TRAP drives all enables to 0 and stays until `rst`.
  - Adds an output `illegal` (1 bit), high while in TRAP; 0 at reset.
- **Macro undefined:**
  - An unrecognised opcode returns to FETCH with no `retire` and no writes, i.e. it executes as a NOP that does not count.
  - No TRAP state and no `illegal` port.

## Test plan
- **Zero-wait lw:** lw (opcode 0000011), `mem_ready`=1 -> `state` 0,1,2,3,4. `reg_write` and `result_src`=01 in cycle 5; `instret` 0->1.
- **sw with stalls:** sw, `mem_ready` low for 3 cycles in MEMWR -> `mem_req`/`mem_we`/`adr_src` held high for 4 cycles. `retire` on the `mem_ready` cycle; total 7 cycles.
- **beq taken / not taken:**
  - `zero`=1 -> `pc_en`=1 in BRANCH.
  - `zero`=0 -> `pc_en`=0.
  - Both cases: 3 cycles, `retire`=1.
- **Back-to-back ALU ops:** R-type then I-type (0110011, 0010011) -> `alu_src_b` 00 then 01. `instret`=2 after 8 cycles.
- **Reset mid-instruction:** `rst` asserted in MEMRD -> `state`=0 and `instret`=0 asynchronously; after release the next instruction fetch proceeds normally.
- **Illegal opcode 1111111:**
  - With TRAP: `illegal`=1 held, `mem_req`=0.
  - Without TRAP: back to FETCH after 2 cycles, `instret` unchanged.
